crossbar_v3: RTL and testbench
==============================

CROSSBAR_V3 -- requirements
Module: crossbar_v3

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 14, number of input channels (>=2).
REQ-002 SHALL have parameter NUM_OUTPUTS, default 16, number of output channels (>=1).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, entries per input FIFO (power of 2, >=2).
REQ-005 SHALL have localparam SEL_W = $clog2(NUM_INPUTS+1); select value >= NUM_INPUTS means output disabled.
REQ-006 SHALL have port clk_gated  input  1  clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid_i  input  [NUM_INPUTS]  per-input valid.
REQ-009 SHALL have port in_data_i  input  [NUM_INPUTS][DATA_WIDTH]  per-input payload.
REQ-010 SHALL have port in_ready_o  output  [NUM_INPUTS]  per-input ready.
REQ-011 SHALL have port out_valid_o  output  [NUM_OUTPUTS]  per-output valid.
REQ-012 SHALL have port out_data_o  output  [NUM_OUTPUTS][DATA_WIDTH]  per-output payload.
REQ-013 SHALL have port out_ready_i  input  [NUM_OUTPUTS]  per-output ready.
REQ-014 SHALL have port cfg_select_i  input  [NUM_OUTPUTS][SEL_W]  new routing, source index per output.
REQ-015 SHALL have port cfg_load_i  input  1  routing load request.
REQ-016 SHALL have port cfg_busy_o  output  1  routing change pending.
REQ-017 SHALL have port drop_cnt_o  output  16  saturating count of dropped unrouted beats.

Function
REQ-018 Each input SHALL own a FIFO_DEPTH FIFO; in_ready_o[i] = FIFO not full; push on in_valid_i & in_ready_o; no bypass: a full FIFO blocks push even if popping that cycle.
REQ-019 Latency SHALL be exactly 1 cycle: a beat pushed at edge N is visible at its outputs' out_data_o after edge N (no combinational in->out path).
REQ-020 Active routing sel_q[j] SHALL select source s; out_data_o[j] = head of FIFO s, else 0 when s >= NUM_INPUTS.
REQ-021 out_valid_o[j] SHALL = (s < NUM_INPUTS) & FIFO s non-empty & !done_q[j] (subject to REQ-026).
REQ-022 Multicast: head of input i SHALL pop only when every output j with sel_q[j]==i has done_q[j]=1 or handshakes (out_valid_o & out_ready_i) this cycle; on pop all those done_q bits clear.
REQ-023 An output handshake not causing a pop SHALL set done_q[j]; a delivered beat is never repeated to the same output.
REQ-024 A non-empty input with zero subscribing outputs SHALL pop one beat per cycle and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-025 cfg_load_i while cfg_busy_o=0 SHALL capture cfg_select_i into a shadow register and set cfg_busy_o next cycle; cfg_load_i while busy SHALL be ignored.
REQ-026 While busy, out_valid_o[j] SHALL be forced 0 unless source head has at least one done_q bit set (finish partial multicasts only).
REQ-027 Commit: at first edge with busy=1 and done_q all zero, sel_q <= shadow and cfg_busy_o clears; new routing is effective the following cycle.
REQ-028 Inputs SHALL keep accepting into FIFOs while busy; no beat lost or duplicated across a routing change.
REQ-029 Out-of-range select values SHALL never index FIFO storage (no X propagation).

Reset
REQ-030 rst_n low SHALL asynchronously clear FIFOs (empty), done_q, shadow, cfg_busy_o, drop_cnt_o; sel_q resets to NUM_INPUTS (all outputs disabled).
REQ-031 During and after reset until routing loads: in_ready_o = 1, out_valid_o = 0, out_data_o = 0; accepted beats drop per REQ-024.
REQ-032 Reset mid-multicast or mid-commit SHALL discard all in-flight beats and pending routing.

Verification
REQ-033 Unicast: route out0<-in2, push 8'hA5 on in2 -> out_valid_o[0] high next cycle, data A5, pops on out_ready_i[0].
REQ-034 Multicast skew: out0,out1<-in1, push 3C; out0 ready, out1 stalled 3 cycles -> out0 sees one beat only, in1 head pops on out1 handshake, done_q cleared.
REQ-035 Backpressure: FIFO_DEPTH=2, outputs stalled, 3 pushes on in0 -> in_ready_o[0] low after 2 accepts; third accepted only after first pop.
REQ-036 Reconfig mid-multicast: out0 done, out1 pending, cfg_load_i -> busy high, out1 completes, commit next edge, no loss or duplication.
REQ-037 Drop: no route to in3, 5 pushes -> drop_cnt_o = 5; preload counter near 16'hFFFF -> saturates.
REQ-038 Async reset asserted mid-traffic -> all outputs to reset values immediately, in_ready_o = 1 after release.

Source files
------------

// File: rtl/crossbar_v3.sv
// Buffered multicast crossbar: one FIFO per input, per-output source select,
// and a shadowed routing update that commits only once no multicast is half delivered.
module crossbar_v3 #(
  parameter int NUM_INPUTS  = 14,
  parameter int NUM_OUTPUTS = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 2,
  localparam int SEL_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                                   clk_gated,
  input  logic                                   rst_n,
  input  logic [NUM_INPUTS-1:0]                  in_valid_i,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_data_i,
  output logic [NUM_INPUTS-1:0]                  in_ready_o,
  output logic [NUM_OUTPUTS-1:0]                 out_valid_o,
  output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data_o,
  input  logic [NUM_OUTPUTS-1:0]                 out_ready_i,
  input  logic [NUM_OUTPUTS-1:0][SEL_W-1:0]      cfg_select_i,
  input  logic                                   cfg_load_i,
  output logic                                   cfg_busy_o,
  output logic [15:0]                            drop_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [SEL_W-1:0] SEL_OFF = SEL_W'(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]  w_empty;
  logic [NUM_INPUTS-1:0]  w_full;
  logic [NUM_INPUTS-1:0]  w_pop;
  logic [DATA_WIDTH-1:0]  w_head [NUM_INPUTS];
  logic [NUM_OUTPUTS-1:0] w_match [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  w_head_done;
  logic [NUM_OUTPUTS-1:0] w_src_ok;
  logic [NUM_OUTPUTS-1:0] w_hs;
  logic [NUM_OUTPUTS-1:0] w_src_pop;
  logic [CW-1:0]          w_drop_n;
  logic [16:0]            w_drop_sum;

  logic [NUM_OUTPUTS-1:0]            r_done;
  logic [NUM_OUTPUTS-1:0][SEL_W-1:0] r_sel;
  logic [NUM_OUTPUTS-1:0][SEL_W-1:0] r_shadow;
  logic                              r_busy;
  logic [15:0]                       r_drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_fifo
      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [AW:0]           r_wptr;
      logic [AW:0]           r_rptr;
      logic                  w_push;

      // Full is judged on registered pointers only, so a same-cycle pop never frees a slot.
      assign w_push         = in_valid_i[gi] & ~w_full[gi];
      assign w_empty[gi]    = (r_wptr == r_rptr);
      assign w_full[gi]     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      assign w_head[gi]     = r_mem[r_rptr[AW-1:0]];
      assign in_ready_o[gi] = ~w_full[gi];

      always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in_data_i[gi];
            r_wptr                <= r_wptr + (AW+1)'(1);
          end
          if (w_pop[gi]) r_rptr <= r_rptr + (AW+1)'(1);
        end
      end
    end
  endgenerate

  // Sources are matched by comparison rather than indexing, so disabled selects touch no FIFO.
  always_comb begin
    w_head_done = '0;
    w_src_ok    = '0;
    w_hs        = '0;
    out_valid_o = '0;
    out_data_o  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) w_match[i] = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      w_src_ok[j] = (r_sel[j] < SEL_OFF);
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (r_sel[j] == SEL_W'(i)) begin
          w_match[i][j] = 1'b1;
          if (r_done[j]) w_head_done[i] = 1'b1;
        end
      end
    end
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_match[i][j]) begin
          out_data_o[j]  = w_head[i];
          out_valid_o[j] = ~w_empty[i] & ~r_done[j] & (~r_busy | w_head_done[i]);
        end
      end
      w_hs[j] = out_valid_o[j] & out_ready_i[j];
    end
  end

  // An input with no subscribers has an all-ones "served" mask, so it drains as drops.
  always_comb begin
    w_pop     = '0;
    w_src_pop = '0;
    w_drop_n  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_pop[i] = ~w_empty[i] & (&(~w_match[i] | r_done | w_hs));
      if (w_pop[i] && (w_match[i] == '0)) w_drop_n = w_drop_n + CW'(1);
    end
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_match[i][j] && w_pop[i]) w_src_pop[j] = 1'b1;
      end
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= '0;
      r_sel      <= {NUM_OUTPUTS{SEL_OFF}};
      r_shadow   <= '0;
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (!w_src_ok[j] || w_src_pop[j]) r_done[j] <= 1'b0;
        else if (w_hs[j])                 r_done[j] <= 1'b1;
      end
      // While busy no fresh head can be offered, so done bits only drain toward commit.
      if (!r_busy) begin
        if (cfg_load_i) begin
          r_shadow <= cfg_select_i;
          r_busy   <= 1'b1;
        end
      end else if (r_done == '0) begin
        r_sel  <= r_shadow;
        r_busy <= 1'b0;
      end
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign cfg_busy_o = r_busy;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_crossbar_v3.sv
// Directed bench for crossbar_v3: a unicast vector table plus hand-written
// sequences for multicast skew, backpressure, reconfiguration, drops and async reset.
module tb_crossbar_v3;
  localparam int NI = 14;
  localparam int NO = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic                  clk_gated = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NI-1:0]         in_valid_i;
  logic [NI-1:0][DW-1:0] in_data_i;
  logic [NI-1:0]         in_ready_o;
  logic [NO-1:0]         out_valid_o;
  logic [NO-1:0][DW-1:0] out_data_o;
  logic [NO-1:0]         out_ready_i;
  logic [NO-1:0][SW-1:0] cfg_select_i;
  logic                  cfg_load_i;
  logic                  cfg_busy_o;
  logic [15:0]           drop_cnt_o;

  int total = 0;
  int bad = 0;

  crossbar_v3 #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .FIFO_DEPTH(2)
  ) dut (
    .clk_gated(clk_gated), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .cfg_select_i(cfg_select_i), .cfg_load_i(cfg_load_i), .cfg_busy_o(cfg_busy_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_gated = ~clk_gated;

  typedef struct {
    int            src;
    int            dst;
    logic [DW-1:0] data;
    logic [NO-1:0] exp_valid;
  } uni_vec_t;

  uni_vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_gated);
    @(negedge clk_gated);
  endtask

  function automatic logic [NO-1:0][SW-1:0] all_off();
    logic [NO-1:0][SW-1:0] r;
    for (int j = 0; j < NO; j++) r[j] = SW'(NI);
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid_i   = '0;
    in_data_i    = '0;
    out_ready_i  = '0;
    cfg_load_i   = 1'b0;
    cfg_select_i = all_off();
  endtask

  task automatic do_reset();
    @(negedge clk_gated);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk_gated);
    @(negedge clk_gated);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic configure(input logic [NO-1:0][SW-1:0] sel);
    int n = 0;
    cfg_select_i = sel;
    cfg_load_i   = 1'b1;
    tick();
    cfg_load_i   = 1'b0;
    cfg_select_i = all_off();
    while (cfg_busy_o && n < 20) begin
      tick();
      n++;
    end
    chk("cfg_commit", {63'd0, cfg_busy_o}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NO-1:0][SW-1:0] sel;
    idle_inputs();
    vecs[0] = '{src: 2,  dst: 0,  data: 32'h0000_00A5, exp_valid: 16'h0001};
    vecs[1] = '{src: 0,  dst: 15, data: 32'hDEAD_BEEF, exp_valid: 16'h8000};
    vecs[2] = '{src: 13, dst: 7,  data: 32'h1234_5678, exp_valid: 16'h0080};
    vecs[3] = '{src: 5,  dst: 3,  data: 32'h0000_0000, exp_valid: 16'h0008};

    // Reset state
    repeat (2) @(negedge clk_gated);
    chk("rst_in_ready", 64'(in_ready_o), 64'h3FFF);
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    chk("rst_out_data_zero", {63'd0, out_data_o == '0}, 64'd1);
    chk("rst_busy", {63'd0, cfg_busy_o}, 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Unicast vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      sel = all_off();
      sel[vecs[v].dst] = SW'(vecs[v].src);
      configure(sel);
      in_valid_i[vecs[v].src] = 1'b1;
      in_data_i[vecs[v].src]  = vecs[v].data;
      #1;
      chk("uni_no_comb_path", 64'(out_valid_o), 64'h0);
      tick();
      in_valid_i = '0;
      chk("uni_valid", 64'(out_valid_o), 64'(vecs[v].exp_valid));
      chk("uni_data", 64'(out_data_o[vecs[v].dst]), 64'(vecs[v].data));
      chk("uni_other_data", 64'(out_data_o[(vecs[v].dst + 1) % NO]), 64'h0);
      out_ready_i[vecs[v].dst] = 1'b1;
      tick();
      out_ready_i = '0;
      chk("uni_popped", 64'(out_valid_o), 64'h0);
      chk("uni_drop", 64'(drop_cnt_o), 64'd0);
      $display("unicast vec %0d: in%0d -> out%0d data=%08h", v, vecs[v].src, vecs[v].dst, vecs[v].data);
    end

    // Multicast with a skewed consumer
    do_reset();
    sel = all_off();
    sel[0] = 4'd1;
    sel[1] = 4'd1;
    configure(sel);
    in_valid_i[1] = 1'b1;
    in_data_i[1]  = 32'h3C;
    tick();
    in_valid_i = '0;
    chk("mc_both_valid", 64'(out_valid_o), 64'h3);
    chk("mc_data0", 64'(out_data_o[0]), 64'h3C);
    chk("mc_data1", 64'(out_data_o[1]), 64'h3C);
    out_ready_i[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mc_out0_single", 64'(out_valid_o), 64'h2);
    end
    out_ready_i[1] = 1'b1;
    tick();
    out_ready_i = '0;
    chk("mc_popped", 64'(out_valid_o), 64'h0);
    in_valid_i[1] = 1'b1;
    in_data_i[1]  = 32'h5A;
    tick();
    in_valid_i = '0;
    chk("mc_done_cleared", 64'(out_valid_o), 64'h3);
    chk("mc_next_data", 64'(out_data_o[0]), 64'h5A);
    out_ready_i[1:0] = 2'b11;
    tick();
    out_ready_i = '0;
    chk("mc_joint_pop", 64'(out_valid_o), 64'h0);
    $display("multicast skew sequence complete");

    // Backpressure on a depth-2 FIFO
    do_reset();
    sel = all_off();
    sel[0] = 4'd0;
    configure(sel);
    in_valid_i[0] = 1'b1;
    in_data_i[0]  = 32'h11;
    tick();
    chk("bp_one_entry_ready", 64'(in_ready_o[0]), 64'd1);
    in_data_i[0] = 32'h22;
    tick();
    chk("bp_full", 64'(in_ready_o[0]), 64'd0);
    in_data_i[0] = 32'h33;
    tick();
    chk("bp_blocked", 64'(in_ready_o[0]), 64'd0);
    chk("bp_head", 64'(out_data_o[0]), 64'h11);
    out_ready_i[0] = 1'b1;
    tick();
    chk("bp_no_bypass", 64'(in_ready_o[0]), 64'd1);
    chk("bp_head2", 64'(out_data_o[0]), 64'h22);
    tick();
    in_valid_i = '0;
    chk("bp_head3", 64'(out_data_o[0]), 64'h33);
    chk("bp_valid3", 64'(out_valid_o), 64'h1);
    tick();
    out_ready_i = '0;
    chk("bp_drained", 64'(out_valid_o), 64'h0);
    $display("backpressure sequence complete");

    // Reconfiguration in the middle of a multicast
    do_reset();
    sel = all_off();
    sel[0] = 4'd1;
    sel[1] = 4'd1;
    configure(sel);
    in_valid_i[1] = 1'b1;
    in_data_i[1]  = 32'hAA;
    tick();
    in_data_i[1] = 32'hBB;
    tick();
    in_valid_i = '0;
    chk("rc_start", 64'(out_valid_o), 64'h3);
    out_ready_i[0] = 1'b1;
    tick();
    out_ready_i = '0;
    chk("rc_out0_done", 64'(out_valid_o), 64'h2);
    sel = all_off();
    sel[2] = 4'd1;
    cfg_select_i = sel;
    cfg_load_i   = 1'b1;
    tick();
    chk("rc_busy", {63'd0, cfg_busy_o}, 64'd1);
    chk("rc_partial_allowed", 64'(out_valid_o), 64'h2);
    sel = all_off();
    sel[3] = 4'd1;
    cfg_select_i = sel;
    tick();
    cfg_load_i   = 1'b0;
    cfg_select_i = all_off();
    chk("rc_still_busy", {63'd0, cfg_busy_o}, 64'd1);
    out_ready_i[1] = 1'b1;
    tick();
    out_ready_i = '0;
    chk("rc_commit_pending", {63'd0, cfg_busy_o}, 64'd1);
    chk("rc_gated", 64'(out_valid_o), 64'h0);
    tick();
    chk("rc_committed", {63'd0, cfg_busy_o}, 64'd0);
    chk("rc_new_route", 64'(out_valid_o), 64'h4);
    chk("rc_new_data", 64'(out_data_o[2]), 64'hBB);
    out_ready_i[2] = 1'b1;
    tick();
    out_ready_i = '0;
    chk("rc_drained", 64'(out_valid_o), 64'h0);
    chk("rc_no_drop", 64'(drop_cnt_o), 64'd0);
    $display("reconfiguration sequence complete");

    // Unrouted drops and saturation
    do_reset();
    in_valid_i[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data_i[3] = DW'(k);
      tick();
    end
    in_valid_i = '0;
    repeat (2) tick();
    chk("drop_five", 64'(drop_cnt_o), 64'd5);
    in_valid_i = '1;
    repeat (4000) tick();
    in_valid_i = '0;
    repeat (2) tick();
    chk("drop_bulk", 64'(drop_cnt_o), 64'hDAC5);
    in_valid_i = '1;
    repeat (1000) tick();
    in_valid_i = '0;
    repeat (2) tick();
    chk("drop_saturated", 64'(drop_cnt_o), 64'hFFFF);
    in_valid_i[3] = 1'b1;
    tick();
    in_valid_i = '0;
    repeat (2) tick();
    chk("drop_no_wrap", 64'(drop_cnt_o), 64'hFFFF);
    $display("drop counter sequence complete");

    // Asynchronous reset during traffic and a pending routing change
    do_reset();
    sel = all_off();
    sel[0] = 4'd0;
    configure(sel);
    in_valid_i[0] = 1'b1;
    in_data_i[0]  = 32'h77;
    tick();
    in_data_i[0] = 32'h88;
    tick();
    in_valid_i = '0;
    chk("ar_full", 64'(in_ready_o[0]), 64'd0);
    chk("ar_valid", 64'(out_valid_o), 64'h1);
    sel = all_off();
    sel[5] = 4'd0;
    cfg_select_i = sel;
    cfg_load_i   = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid_o), 64'h0);
    chk("ar_out_data_zero", {63'd0, out_data_o == '0}, 64'd1);
    chk("ar_in_ready", 64'(in_ready_o), 64'h3FFF);
    chk("ar_busy", {63'd0, cfg_busy_o}, 64'd0);
    @(negedge clk_gated);
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 64'(out_valid_o), 64'h0);
    chk("ar_post_ready", 64'(in_ready_o), 64'h3FFF);
    chk("ar_post_busy", {63'd0, cfg_busy_o}, 64'd0);
    $display("async reset sequence complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
